// File: rtl/encrypt_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : encrypt_arbiter
//  Purpose  : Round-robin scheduler sharing one encrypt_unit datapath between
//             N_REQ byte-stream requesters. Grants per packet (capped at
//             BURST bytes), drives the unit's en/din, and carries a tag
//             pipeline of PIPE_LAT stages so each encrypted byte comes back
//             labelled with its source id and last flag.
//  Ports    : clk, rst (async, active-low)
//             req_valid/req_data/req_last/req_ready : host-side byte streams
//             enc_en/enc_din -> encrypt_unit, enc_v/enc_dout <- encrypt_unit
//             out_valid/out_data/out_id/out_last    : encrypted byte stream
//             busy     : a grant is active
//             tag_err  : sticky, enc_v disagreed with the tag pipeline
//  Revision : 1.0 - initial release
// ============================================================================
module encrypt_arbiter #(
    parameter int N_REQ    = 4,
    parameter int BURST    = 8,
    parameter int PIPE_LAT = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [8*N_REQ-1:0]         req_data,
    input  logic [N_REQ-1:0]           req_last,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       enc_en,
    output logic [7:0]                 enc_din,
    input  logic                       enc_v,
    input  logic [7:0]                 enc_dout,
    output logic                       out_valid,
    output logic [7:0]                 out_data,
    output logic [$clog2(N_REQ)-1:0]   out_id,
    output logic                       out_last,
    output logic                       busy,
    output logic                       tag_err
);

    localparam int IDW = $clog2(N_REQ);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]       cnt_q, cnt_d;

    logic             transfer;
    logic             byte_last;
    logic [IDW-1:0]   sel_id;
    logic             sel_found;

    logic             tag_tv_q   [PIPE_LAT];
    logic [IDW-1:0]   tag_id_q   [PIPE_LAT];
    logic             tag_last_q [PIPE_LAT];
    logic             tag_err_q;

    // A byte closes the grant either because the packet ends or because the
    // burst budget is exhausted; both cases are reported downstream as last.
    assign byte_last = req_last[gnt_q] | (cnt_q == 8'(BURST - 1));
    assign transfer  = (state_q == S_BUSY) & req_valid[gnt_q];

    // Round-robin search starting just after the previously granted id.
    always_comb begin : p_select
        int          idx;
        logic [IDW-1:0] idx_id;
        idx       = 0;
        idx_id    = '0;
        sel_found = 1'b0;
        sel_id    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx    = (int'(rr_ptr_q) + k) % N_REQ;
            idx_id = IDW'(idx);
            if (!sel_found && req_valid[idx_id]) begin
                sel_found = 1'b1;
                sel_id    = idx_id;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        req_ready = '0;
        busy      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    gnt_d    = sel_id;
                    rr_ptr_d = sel_id;
                    cnt_d    = 8'd0;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                busy             = 1'b1;
                req_ready[gnt_q] = 1'b1;
                if (transfer) begin
                    cnt_d = cnt_q + 8'd1;
                    if (byte_last) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_q    <= '0;
            rr_ptr_q <= IDW'(N_REQ - 1);
            cnt_q    <= 8'd0;
        end else begin
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign enc_en  = transfer;
    assign enc_din = transfer ? req_data[{gnt_q, 3'b000} +: 8] : 8'd0;

    // Tag pipeline: stage PIPE_LAT-1 lines up with the unit's enc_v.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                tag_tv_q[i]   <= 1'b0;
                tag_id_q[i]   <= '0;
                tag_last_q[i] <= 1'b0;
            end
        end else begin
            tag_tv_q[0]   <= transfer;
            tag_id_q[0]   <= gnt_q;
            tag_last_q[0] <= byte_last;
            for (int i = 1; i < PIPE_LAT; i++) begin
                tag_tv_q[i]   <= tag_tv_q[i-1];
                tag_id_q[i]   <= tag_id_q[i-1];
                tag_last_q[i] <= tag_last_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_err_q <= 1'b0;
        end else if (enc_v != tag_tv_q[PIPE_LAT-1]) begin
            tag_err_q <= 1'b1;
        end
    end

    assign tag_err = tag_err_q;

    // The encrypt_unit may not share our reset, so its result is masked
    // while rst is low to keep the outputs at their reset values.
    assign out_valid = rst & enc_v;
    assign out_data  = rst ? enc_dout : 8'd0;
    assign out_id    = out_valid ? tag_id_q[PIPE_LAT-1] : '0;
    assign out_last  = out_valid & tag_last_q[PIPE_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_encrypt_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_encrypt_arbiter
//  Purpose  : Self-checking bench for encrypt_arbiter. Requester packets are
//             loaded into per-requester byte memories; a packet-level
//             round-robin model predicts grant order and the encrypted
//             output stream, which is compared cycle by cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_encrypt_arbiter;

    localparam int N     = 4;
    localparam int BURST = 8;
    localparam int LAT   = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid, req_last, req_ready;
    logic [8*N-1:0]   req_data;
    logic             enc_en, enc_v, out_valid, out_last, busy, tag_err;
    logic [7:0]       enc_din, enc_dout, out_data;
    logic [1:0]       out_id;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    encrypt_arbiter #(.N_REQ(N), .BURST(BURST), .PIPE_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .enc_en(enc_en), .enc_din(enc_din), .enc_v(enc_v), .enc_dout(enc_dout),
        .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
        .out_last(out_last), .busy(busy), .tag_err(tag_err)
    );

    // ---------------- encrypt_unit model (optionally one cycle early) -------
    logic       early;
    logic       pv [LAT];
    logic [7:0] pd [LAT];

    function automatic logic [7:0] enc_f(input logic [7:0] b);
        return {b[4:0], b[7:5]} ^ 8'hC3;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) begin pv[i] <= 1'b0; pd[i] <= 8'd0; end
        end else begin
            pv[0] <= enc_en;
            pd[0] <= enc_f(enc_din);
            for (int i = 1; i < LAT; i++) begin pv[i] <= pv[i-1]; pd[i] <= pd[i-1]; end
        end
    end
    assign enc_v    = early ? pv[LAT-2] : pv[LAT-1];
    assign enc_dout = early ? pd[LAT-2] : pd[LAT-1];

    // ---------------- sources and reference model ----------------------------
    logic [8:0]  mem [N][256];
    int          wr [N];
    int          rd [N];
    logic [10:0] exp_q [$];   // {id, last, encrypted byte}
    int          exp_g [$];   // expected grant order
    int          obs_g [$];
    int          run_en, run_first_en, run_idle, exp_total;

    task automatic add_byte(input int id, input logic [7:0] b, input logic last);
        mem[id][wr[id]] = {last, b};
        wr[id]++;
    endtask

    task automatic add_pkt(input int id, input int len);
        for (int j = 0; j < len; j++) add_byte(id, 8'($urandom), (j == len - 1));
    endtask

    // Packet-level schedule: each grant goes to the next requester (after the
    // previous grantee) that still has bytes, and lasts until end of packet
    // or BURST bytes, whichever comes first.
    task automatic build_model();
        int mrd [N];
        int ptr, id, taken;
        bit done, lastf;
        logic [8:0] w;
        exp_q.delete();
        exp_g.delete();
        for (int i = 0; i < N; i++) mrd[i] = rd[i];
        ptr = N - 1;
        forever begin
            id = -1;
            for (int k = 1; k <= N; k++)
                if (id < 0 && mrd[(ptr + k) % N] < wr[(ptr + k) % N]) id = (ptr + k) % N;
            if (id < 0) break;
            exp_g.push_back(id);
            taken = 0;
            done  = 0;
            while (!done) begin
                w = mem[id][mrd[id]];
                mrd[id]++;
                taken++;
                lastf = w[8] || (taken == BURST);
                exp_q.push_back({2'(id), lastf, enc_f(w[7:0])});
                done = lastf;
            end
            ptr = id;
        end
        exp_total = exp_q.size();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0;
        for (int i = 0; i < N; i++) begin wr[i] = 0; rd[i] = 0; end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Drives all loaded packets; bubbles (3-cycle valid drops) are only
    // inserted while the requester holds the grant.
    task automatic run_traffic(input int pct, input int max_cyc);
        int cyc, tail, xid, pending, t;
        int gap [N];
        int en_t [$];
        logic [N-1:0]   v, l;
        logic [8*N-1:0] d;
        logic [10:0]    e;
        logic           prev_busy;
        bit             ok;
        build_model();
        obs_g.delete();
        run_en = 0; run_first_en = -1; run_idle = 0;
        prev_busy = 1'b0; cyc = 0; tail = 0;
        for (int i = 0; i < N; i++) gap[i] = 0;
        while (cyc < max_cyc && tail < LAT + 3) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                d[8*i +: 8] = 8'($urandom);
                v[i] = 1'b0; l[i] = 1'b0;
                if (rd[i] < wr[i]) begin
                    v[i] = 1'b1;
                    d[8*i +: 8] = mem[i][rd[i]][7:0];
                    l[i] = mem[i][rd[i]][8];
                    if (req_ready[i]) begin
                        if (gap[i] > 0) begin gap[i]--; v[i] = 1'b0; end
                        else if ($urandom_range(99) < pct) begin gap[i] = 2; v[i] = 1'b0; end
                    end
                end
            end
            req_valid = v; req_data = d; req_last = l;
            #1;
            if (busy && !prev_busy) begin
                xid = -1;
                for (int i = 0; i < N; i++) if (req_ready[i]) xid = i;
                obs_g.push_back(xid);
            end
            pending = 0;
            for (int i = 0; i < N; i++) pending += wr[i] - rd[i];
            if (!busy && pending > 0) run_idle++;
            xid = -1;
            for (int i = 0; i < N; i++) if (v[i] && req_ready[i]) xid = i;
            n_total++;
            if (enc_en !== (xid >= 0)) $display("FAIL enc_en cyc%0d: got %b want %b", cyc, enc_en, xid >= 0);
            else n_pass++;
            n_total++;
            if (xid >= 0) begin
                en_t.push_back(cyc);
                run_en++;
                if (run_first_en < 0) run_first_en = cyc;
                if (enc_din !== d[8*xid +: 8]) $display("FAIL enc_din cyc%0d: got %h want %h", cyc, enc_din, d[8*xid +: 8]);
                else n_pass++;
                rd[xid]++;
            end else begin
                if (enc_din !== 8'd0) $display("FAIL enc_din_idle cyc%0d: got %h want 00", cyc, enc_din);
                else n_pass++;
            end
            if (out_valid) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL out_extra cyc%0d: got out_valid=1 want 0", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_id, out_last, out_data} !== e)
                        $display("FAIL out_beat cyc%0d: got id=%0d last=%b data=%h want id=%0d last=%b data=%h",
                                 cyc, out_id, out_last, out_data, e[10:9], e[8], e[7:0]);
                    else n_pass++;
                end
                n_total++;
                t = (en_t.size() > 0) ? en_t.pop_front() : -100;
                if (cyc - t != LAT) $display("FAIL out_latency cyc%0d: got %0d want %0d", cyc, cyc - t, LAT);
                else n_pass++;
            end else begin
                n_total++;
                if (out_id !== 2'd0 || out_last !== 1'b0)
                    $display("FAIL out_tag_idle cyc%0d: got id=%0d last=%b want 0/0", cyc, out_id, out_last);
                else n_pass++;
            end
            prev_busy = busy;
            cyc++;
            pending = 0;
            for (int i = 0; i < N; i++) pending += wr[i] - rd[i];
            if (pending == 0 && exp_q.size() == 0) tail++;
        end
        n_total++;
        if (tail < LAT + 3) $display("FAIL traffic_timeout: got %0d outputs missing want 0", exp_q.size());
        else n_pass++;
        ok = (obs_g.size() == exp_g.size());
        for (int i = 0; ok && i < exp_g.size(); i++) if (obs_g[i] != exp_g[i]) ok = 0;
        n_total++;
        if (!ok) $display("FAIL grant_order: got %p want %p", obs_g, exp_g);
        else n_pass++;
        n_total++;
        if (run_idle != exp_g.size()) $display("FAIL idle_gaps: got %0d want %0d", run_idle, exp_g.size());
        else n_pass++;
        n_total++;
        if (run_en != exp_total) $display("FAIL enc_en_count: got %0d want %0d", run_en, exp_total);
        else n_pass++;
        n_total++;
        if (tag_err !== 1'b0) $display("FAIL tag_err_clean: got %b want 0", tag_err);
        else n_pass++;
        @(negedge clk);
        req_valid = '0; req_last = '0;
    endtask

    // ---------------- scenarios ----------------------------------------------
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        req_valid = '1; req_data = $urandom; req_last = 4'($urandom);
        repeat (3) @(negedge clk);
        #1;
        n_total++;
        if ({req_ready, enc_en, enc_din, busy, tag_err} !== '0)
            $display("FAIL reset_ctrl: got ready=%b en=%b din=%h busy=%b err=%b want 0",
                     req_ready, enc_en, enc_din, busy, tag_err);
        else n_pass++;
        n_total++;
        if ({out_valid, out_data, out_id, out_last} !== '0)
            $display("FAIL reset_out: got v=%b d=%h id=%0d l=%b want 0", out_valid, out_data, out_id, out_last);
        else n_pass++;
        req_valid = '0; req_last = '0;
    endtask

    task automatic test_single();
        do_reset();
        add_byte(2, 8'h11, 1'b0);
        add_byte(2, 8'h22, 1'b0);
        add_byte(2, 8'h33, 1'b1);
        run_traffic(0, 100);
        n_total++;
        if (run_first_en != 1) $display("FAIL single_first_en: got cycle %0d want 1", run_first_en);
        else n_pass++;
        n_total++;
        if (run_en != 3) $display("FAIL single_en_count: got %0d want 3", run_en);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int rr_exp [6];
        bit ok;
        rr_exp = '{0, 1, 2, 3, 0, 1};
        do_reset();
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < N; i++) add_byte(i, 8'($urandom), 1'b1);
        run_traffic(0, 200);
        ok = (obs_g.size() >= 6);
        for (int i = 0; ok && i < 6; i++) if (obs_g[i] != rr_exp[i]) ok = 0;
        n_total++;
        if (!ok) $display("FAIL rr_order: got %p want 0,1,2,3,0,1,...", obs_g);
        else n_pass++;
    endtask

    task automatic test_burst_cap();
        do_reset();
        add_pkt(0, 20);
        add_pkt(1, 2);
        run_traffic(0, 300);
        n_total++;
        if (run_en != 22) $display("FAIL burst_en_count: got %0d want 22", run_en);
        else n_pass++;
        n_total++;
        if (obs_g.size() != 4 || obs_g[0] != 0 || obs_g[1] != 1 || obs_g[2] != 0 || obs_g[3] != 0)
            $display("FAIL burst_grants: got %p want 0,1,0,0", obs_g);
        else n_pass++;
    endtask

    task automatic test_bubbles();
        do_reset();
        add_pkt(1, 12);
        add_pkt(3, 5);
        add_pkt(1, 3);
        run_traffic(40, 2000);
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            do_reset();
            for (int i = 0; i < N; i++)
                for (int p = $urandom_range(0, 3); p > 0; p--) add_pkt(i, $urandom_range(1, 20));
            run_traffic($urandom_range(0, 30), 3000);
        end
    endtask

    task automatic test_async_reset();
        logic [N-1:0] m;
        int k, want;
        do_reset();
        @(negedge clk);
        req_valid = '1; req_last = '0; req_data = $urandom;
        k = 0;
        while (!busy && k < 10) begin @(negedge clk); k++; end
        repeat ($urandom_range(0, 5)) @(negedge clk);
        #($urandom_range(1, 3));
        rst = 1'b0;
        #1;
        n_total++;
        if ({req_ready, enc_en, enc_din, busy, out_valid, out_data, out_id, out_last, tag_err} !== '0)
            $display("FAIL async_reset_outputs: got ready=%b en=%b din=%h busy=%b v=%b d=%h id=%0d l=%b err=%b want 0",
                     req_ready, enc_en, enc_din, busy, out_valid, out_data, out_id, out_last, tag_err);
        else n_pass++;
        m = 4'($urandom_range(1, 15));
        req_valid = m;
        want = -1;
        for (int i = N - 1; i >= 0; i--) if (m[i]) want = i;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_total++;
        if (busy !== 1'b1 || req_ready !== 4'(1 << want))
            $display("FAIL async_first_grant: got busy=%b ready=%b want 1/%b (mask %b)", busy, req_ready, 4'(1 << want), m);
        else n_pass++;
        req_valid = '0;
    endtask

    task automatic test_tag_err();
        int k;
        do_reset();
        early = 1'b1;
        @(negedge clk);
        req_valid = 4'b0001; req_data = 32'h55; req_last = 4'b0001;
        k = 0;
        while (!req_ready[0] && k < 10) begin @(negedge clk); k++; end
        n_total++;
        if (!req_ready[0]) $display("FAIL tag_grant_wait: got ready=%b want 0001", req_ready);
        else n_pass++;
        @(negedge clk);
        req_valid = '0; req_last = '0;
        repeat (5) @(negedge clk);
        n_total++;
        if (tag_err !== 1'b1) $display("FAIL tag_err_set: got %b want 1", tag_err);
        else n_pass++;
        repeat (5) @(negedge clk);
        n_total++;
        if (tag_err !== 1'b1) $display("FAIL tag_err_sticky: got %b want 1", tag_err);
        else n_pass++;
        early = 1'b0;
        do_reset();
        @(negedge clk);
        n_total++;
        if (tag_err !== 1'b0) $display("FAIL tag_err_reset: got %b want 0", tag_err);
        else n_pass++;
    endtask

    initial begin
        early = 1'b0;
        rst = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0;
        for (int i = 0; i < N; i++) begin wr[i] = 0; rd[i] = 0; end
        test_reset();
        test_single();
        test_round_robin();
        test_burst_cap();
        test_bubbles();
        test_random();
        test_async_reset();
        test_tag_err();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/encrypt_arbiter.md
Name: encrypt_arbiter

Overview:
Round-robin scheduler that shares one encrypt_unit datapath between N_REQ independent byte-stream requesters.
- Grants the datapath per packet, capped at BURST bytes per grant.
- Drives encrypt_unit en/din.
- Tracks the fixed pipe latency so every encrypted byte returns with the source id and last flag.
- Sits between the host-side stream interfaces and the encrypt_unit instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
BURST, 8, max bytes transferred per grant (1..255)
PIPE_LAT, 2, encrypt_unit en-to-v latency in cycles (>=1)

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-low
req_valid  input  N_REQ  per-requester byte valid
req_data  input  8*N_REQ  per-requester byte; requester i at [8i+7:8i]
req_last  input  N_REQ  marks final byte of the packet
req_ready  output  N_REQ  per-requester accept
enc_en  output  1  to encrypt_unit en
enc_din  output  8  to encrypt_unit din
enc_v  input  1  from encrypt_unit v
enc_dout  input  8  from encrypt_unit dout
out_valid  output  1  encrypted byte valid
out_data  output  8  encrypted byte
out_id  output  $clog2(N_REQ)  source requester of out_data
out_last  output  1  out_data is the last byte of its packet
busy  output  1  grant active
tag_err  output  1  sticky: enc_v disagreed with the tag pipeline

Behaviour:
- FSM states are IDLE and BUSY. Registers: gnt (id), rr_ptr (last granted id), cnt (bytes this grant).
- Reset (rst=0, async): state=IDLE, gnt=0, rr_ptr=N_REQ-1, cnt=0, tag pipe cleared, tag_err=0.
- Reset values of outputs: all req_ready=0, enc_en=0, enc_din=0, out_valid=0, out_data=0, out_id=0, out_last=0, busy=0.
- IDLE:
  - If any req_valid is high, select the first valid requester searching rr_ptr+1, rr_ptr+2, ... mod N_REQ.
  - Next cycle: gnt=selected, rr_ptr=selected, cnt=0, state=BUSY.
  - If no req_valid is high, stay in IDLE.
- BUSY:
  - busy=1.
  - req_ready[gnt]=1 combinationally; all other req_ready bits are 0.
  - Transfer = req_valid[gnt] & req_ready[gnt].
  - enc_en = transfer; enc_din = req_data[gnt] (combinational, zero when no transfer).
  - Each transfer increments cnt.
- Grant end: a transfer with req_last[gnt]=1, or a transfer where cnt==BURST-1, sets state=IDLE the next cycle.
  - Between grants there is exactly one IDLE cycle with no transfers.
- Packet split: a packet longer than BURST is split. The same requester may be regranted only after the round-robin search passes all other valid requesters.
- Bubbles: while in BUSY, a requester holding req_valid low produces bubbles. The grant is held with no timeout.
- Tag pipeline: shift register of depth PIPE_LAT carrying {tv, id, last}.
  - Stage 0 loads {transfer, gnt, req_last[gnt] | cnt==BURST-1}.
  - The stage PIPE_LAT-1 output is aligned with enc_v.
- Output path, combinational pass-through of the encrypt_unit result:
  - out_valid = enc_v; out_data = enc_dout.
  - out_id and out_last come from the tag output when enc_v=1, otherwise 0.
  - out_last is also asserted on a BURST-truncated final byte.
- tag_err: set when enc_v != tag tv at the tag output. Cleared only by reset.
- There is no backpressure on the output side; the downstream consumer must accept every out_valid.
- Reset mid-packet: the grant is abandoned and in-flight tags are dropped. The requester restarts the packet after reset.
- Simultaneous requests: order strictly follows the rr_ptr rotation. With all valid after reset, the grant order is 0,1,2,3,0,...

Test Plan:
1. Single requester: reset, req_valid[2]=1, 3 bytes 0x11,0x22,0x33 with last on 0x33 -> grant goes to req 2 in the cycle after valid. enc_en is high for 3 cycles, then 1 IDLE cycle. out_valid is high for 3 cycles starting PIPE_LAT=2 cycles after the first enc_en, with out_id=2 throughout and out_last only on the third output.
2. Round-robin fairness: all 4 requesters send 1-byte packets continuously -> grants are 0,1,2,3,0,1 with every grant separated by exactly one IDLE cycle. out_id follows the same sequence.
3. BURST cap: req 0 sends a 20-byte packet while req 1 sends a 2-byte packet -> req 0 gets 8 bytes (out_last on byte 8), then req 1 gets 2, then req 0 gets 8, then req 0 gets 4 (last). The total enc_en count is 22.
4. Bubbles: the granted requester drops req_valid for 3 cycles mid-packet -> the grant is held, enc_en=0 and cnt is frozen during the gap, and out_id stays correct after the gap.
5. Async reset mid-grant: assert rst=0 at an arbitrary phase in BUSY -> all outputs go to 0 immediately. After release, the first grant goes to the lowest-index valid requester.
6. Tag check: force enc_v high one cycle early via a mismatched-latency model -> tag_err=1 and stays 1 until reset. With a correct PIPE_LAT model, tag_err stays 0.
